ccu_seq: RTL and testbench

Parametrised successor of the top-level central control unit. It sequences a whole network: a configuration fetch, then per-layer waits on all global-buffer banks, then compute, with patch, frame and layer counting and per-level reset pulses. It sits at the top of the accelerator, driving the config interface, global-buffer banks and PE array control.

---
 rtl/ccu_pkg.sv | 19 +
 rtl/ccu_cnt.sv | 34 +++
 rtl/ccu_seq.sv | 168 ++++++++++++++++
 tb/tb_ccu_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_pkg.sv
// Shared definitions for the central control unit sequencer: state
// encoding and default field widths.
package ccu_pkg;

  // Sequencer state encoding (kept as plain 3-bit constants for
  // compatibility with the older control unit and its debug taps).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CFG     = 3'd1;
  localparam logic [2:0] ST_WAITGBF = 3'd2;
  localparam logic [2:0] ST_CMP     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Default widths of the loop counters and the number of buffer banks.
  localparam int DEF_LAYER_W = 4;
  localparam int DEF_FRM_W   = 8;
  localparam int DEF_PAT_W   = 8;
  localparam int DEF_NUM_GBF = 2;

endpackage

// File: rtl/ccu_cnt.sv
// Loop counter used for the patch, frame and layer levels. The count
// wraps naturally at W bits; 'last' flags the final iteration so the
// parent can decide whether to roll over into the next level.
module ccu_cnt
  import ccu_pkg::*;
#(
  parameter int W = DEF_PAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_reg;

  // Clear takes priority over increment so a roll-over always lands on 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign last = (cnt_reg == max);

endmodule

// File: rtl/ccu_seq.sv
// Top-level network sequencer: fetches a configuration (or reuses the
// stored one), then for each layer waits for all global-buffer banks and
// runs the patch/frame loops, emitting per-level reset/start pulses.
module ccu_seq
  import ccu_pkg::*;
#(
  parameter int LAYER_W = DEF_LAYER_W,
  parameter int FRM_W   = DEF_FRM_W,
  parameter int PAT_W   = DEF_PAT_W,
  parameter int NUM_GBF = DEF_NUM_GBF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_reuse,
  output logic               cfg_req,
  input  logic               ifcfg_rddone,
  input  logic [LAYER_W-1:0] cfg_num_layer,
  input  logic [FRM_W-1:0]   cfg_num_frm,
  input  logic [PAT_W-1:0]   cfg_num_pat,
  input  logic [NUM_GBF-1:0] gbf_val,
  input  logic               pat_done,
  output logic               top_sta,
  output logic               rst_layer,
  output logic               rst_frm,
  output logic               net_done,
  output logic               if_val,
  output logic               cfg_loaded,
  output logic [LAYER_W-1:0] layer_idx,
  output logic [FRM_W-1:0]   frm_idx,
  output logic [PAT_W-1:0]   pat_idx
);

  logic [2:0]         state_reg, state_next;
  logic               cfg_req_reg, if_val_reg, cfg_loaded_reg;
  logic               top_sta_reg, top_sta_next;
  logic               rst_layer_reg, rst_layer_next;
  logic               rst_frm_reg, rst_frm_next;
  logic               net_done_reg, net_done_next;
  logic               cfg_load;
  logic [LAYER_W-1:0] cfg_layer_reg;
  logic [FRM_W-1:0]   cfg_frm_reg;
  logic [PAT_W-1:0]   cfg_pat_reg;

  logic pat_last, frm_last, lay_last;
  logic pat_evt, pat_inc, pat_clr, frm_inc, frm_clr, lay_inc, lay_clr;

  // Nested loop control: each level rolls over only when every inner
  // level is on its last iteration. The outermost roll-over clears all
  // indices on the way into DONE.
  assign pat_evt = (state_reg == ST_CMP) && pat_done;
  assign pat_inc = pat_evt && !pat_last;
  assign pat_clr = pat_evt && pat_last;
  assign frm_inc = pat_clr && !frm_last;
  assign frm_clr = pat_clr && frm_last;
  assign lay_inc = frm_clr && !lay_last;
  assign lay_clr = frm_clr && lay_last;

  ccu_cnt #(.W(PAT_W)) u_pat_cnt (
    .clk (clk), .rst (rst), .inc (pat_inc), .clr (pat_clr),
    .max (cfg_pat_reg), .cnt (pat_idx), .last (pat_last)
  );

  ccu_cnt #(.W(FRM_W)) u_frm_cnt (
    .clk (clk), .rst (rst), .inc (frm_inc), .clr (frm_clr),
    .max (cfg_frm_reg), .cnt (frm_idx), .last (frm_last)
  );

  ccu_cnt #(.W(LAYER_W)) u_lay_cnt (
    .clk (clk), .rst (rst), .inc (lay_inc), .clr (lay_clr),
    .max (cfg_layer_reg), .cnt (layer_idx), .last (lay_last)
  );

  // Next-state and next-pulse decode; pulses are computed on the
  // transition so they appear registered in the first cycle of the state.
  always_comb begin
    state_next     = state_reg;
    top_sta_next   = 1'b0;
    rst_layer_next = 1'b0;
    rst_frm_next   = 1'b0;
    net_done_next  = 1'b0;
    cfg_load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (cfg_reuse && cfg_loaded_reg) begin
            state_next     = ST_WAITGBF;
            rst_layer_next = 1'b1;
          end else begin
            state_next = ST_CFG;
          end
        end
      end
      ST_CFG: begin
        if (ifcfg_rddone) begin
          cfg_load       = 1'b1;
          state_next     = ST_WAITGBF;
          rst_layer_next = 1'b1;
        end
      end
      ST_WAITGBF: begin
        if (&gbf_val) begin
          state_next   = ST_CMP;
          top_sta_next = 1'b1;
        end
      end
      ST_CMP: begin
        if (frm_clr) begin
          if (lay_last) begin
            state_next    = ST_DONE;
            net_done_next = 1'b1;
          end else begin
            state_next     = ST_WAITGBF;
            rst_layer_next = 1'b1;
          end
        end else if (pat_clr) begin
          rst_frm_next = 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, registered outputs and the stored configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cfg_req_reg    <= 1'b0;
      if_val_reg     <= 1'b0;
      cfg_loaded_reg <= 1'b0;
      top_sta_reg    <= 1'b0;
      rst_layer_reg  <= 1'b0;
      rst_frm_reg    <= 1'b0;
      net_done_reg   <= 1'b0;
      cfg_layer_reg  <= '0;
      cfg_frm_reg    <= '0;
      cfg_pat_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      cfg_req_reg   <= (state_next == ST_CFG);
      if_val_reg    <= (state_next != ST_IDLE);
      top_sta_reg   <= top_sta_next;
      rst_layer_reg <= rst_layer_next;
      rst_frm_reg   <= rst_frm_next;
      net_done_reg  <= net_done_next;
      if (cfg_load) begin
        cfg_loaded_reg <= 1'b1;
        cfg_layer_reg  <= cfg_num_layer;
        cfg_frm_reg    <= cfg_num_frm;
        cfg_pat_reg    <= cfg_num_pat;
      end
    end
  end

  assign cfg_req    = cfg_req_reg;
  assign if_val     = if_val_reg;
  assign cfg_loaded = cfg_loaded_reg;
  assign top_sta    = top_sta_reg;
  assign rst_layer  = rst_layer_reg;
  assign rst_frm    = rst_frm_reg;
  assign net_done   = net_done_reg;

endmodule

// File: tb/tb_ccu_seq.sv
// Bench for ccu_seq: randomized and directed runs checked every cycle
// against a reference model that tracks a run as a flat count of
// completed patches and derives indices and pulses arithmetically.
module tb_ccu_seq;

  localparam int LW = 4;
  localparam int FW = 8;
  localparam int PW = 8;
  localparam int NG = 2;

  localparam int P_IDLE = 0;
  localparam int P_CFG  = 1;
  localparam int P_WAIT = 2;
  localparam int P_CMP  = 3;
  localparam int P_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cfg_reuse = 1'b0;
  logic          ifcfg_rddone = 1'b0;
  logic [LW-1:0] cfg_num_layer = '0;
  logic [FW-1:0] cfg_num_frm = '0;
  logic [PW-1:0] cfg_num_pat = '0;
  logic [NG-1:0] gbf_val = '0;
  logic          pat_done = 1'b0;
  logic          cfg_req, top_sta, rst_layer, rst_frm, net_done, if_val, cfg_loaded;
  logic [LW-1:0] layer_idx;
  logic [FW-1:0] frm_idx;
  logic [PW-1:0] pat_idx;

  always #5 clk = ~clk;

  ccu_seq #(.LAYER_W(LW), .FRM_W(FW), .PAT_W(PW), .NUM_GBF(NG)) dut (
    .clk (clk), .rst (rst), .start (start), .cfg_reuse (cfg_reuse),
    .cfg_req (cfg_req), .ifcfg_rddone (ifcfg_rddone),
    .cfg_num_layer (cfg_num_layer), .cfg_num_frm (cfg_num_frm),
    .cfg_num_pat (cfg_num_pat), .gbf_val (gbf_val), .pat_done (pat_done),
    .top_sta (top_sta), .rst_layer (rst_layer), .rst_frm (rst_frm),
    .net_done (net_done), .if_val (if_val), .cfg_loaded (cfg_loaded),
    .layer_idx (layer_idx), .frm_idx (frm_idx), .pat_idx (pat_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase, patches completed in this run, stored config.
  int m_phase = P_IDLE;
  int m_k = 0;
  int m_l = 0, m_f = 0, m_p = 0;
  bit m_loaded = 1'b0;
  bit e_rl, e_ts, e_rf, e_nd;
  int obs_rf, obs_rl, obs_ts, obs_nd, obs_cfg;
  int wcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs the bench drove.
  task automatic model_edge();
    int fp;
    e_rl = 1'b0; e_ts = 1'b0; e_rf = 1'b0; e_nd = 1'b0;
    if (rst) begin
      m_phase = P_IDLE; m_k = 0; m_loaded = 1'b0;
      m_l = 0; m_f = 0; m_p = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          if (cfg_reuse && m_loaded) begin m_phase = P_WAIT; e_rl = 1'b1; end
          else m_phase = P_CFG;
        end
        P_CFG: if (ifcfg_rddone) begin
          m_l = int'(cfg_num_layer); m_f = int'(cfg_num_frm); m_p = int'(cfg_num_pat);
          m_loaded = 1'b1; m_phase = P_WAIT; e_rl = 1'b1;
        end
        P_WAIT: if (gbf_val == '1) begin m_phase = P_CMP; e_ts = 1'b1; end
        P_CMP: if (pat_done) begin
          fp = (m_f + 1) * (m_p + 1);
          m_k++;
          if (m_k == (m_l + 1) * fp) begin m_phase = P_DONE; e_nd = 1'b1; m_k = 0; end
          else if (m_k % fp == 0) begin m_phase = P_WAIT; e_rl = 1'b1; end
          else if (m_k % (m_p + 1) == 0) e_rf = 1'b1;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // One clock: update the model at the edge, compare every output 1 ns later.
  task automatic step();
    int fp;
    @(posedge clk);
    model_edge();
    #1;
    fp = (m_f + 1) * (m_p + 1);
    chk("cfg_req",    32'(cfg_req),    32'(m_phase == P_CFG));
    chk("if_val",     32'(if_val),     32'(m_phase != P_IDLE));
    chk("cfg_loaded", 32'(cfg_loaded), 32'(m_loaded));
    chk("rst_layer",  32'(rst_layer),  32'(e_rl));
    chk("top_sta",    32'(top_sta),    32'(e_ts));
    chk("rst_frm",    32'(rst_frm),    32'(e_rf));
    chk("net_done",   32'(net_done),   32'(e_nd));
    chk("layer_idx",  32'(layer_idx),  32'(m_k / fp));
    chk("frm_idx",    32'(frm_idx),    32'((m_k / (m_p + 1)) % (m_f + 1)));
    chk("pat_idx",    32'(pat_idx),    32'(m_k % (m_p + 1)));
    obs_rf += int'(rst_frm);
    obs_rl += int'(rst_layer);
    obs_ts += int'(top_sta);
    obs_nd += int'(net_done);
    obs_cfg += int'(cfg_req);
  endtask

  // gmode: 0 random banks, 1 partial-valid held 10 cycles per wait, 2 always valid.
  task automatic drive_gbf(input int gmode);
    if (gmode == 2) gbf_val = '1;
    else if (gmode == 1 && m_phase == P_WAIT) begin
      gbf_val = (wcnt < 10) ? NG'(1) : '1;
      wcnt++;
    end else begin
      wcnt = 0;
      gbf_val = ($urandom % 3 == 0) ? '1 : NG'($urandom);
    end
  endtask

  // One network run from IDLE; rst_at >= 0 asserts rst when that many
  // patches have completed. Stray start/pat_done/rddone are mixed in.
  task automatic run(input bit reuse, input int l, input int f, input int p,
                     input int gmode, input bit pd_all, input int rst_at);
    int cyc;
    obs_rf = 0; obs_rl = 0; obs_ts = 0; obs_nd = 0; obs_cfg = 0; wcnt = 0;
    rst = 1'b0; start = 1'b1; cfg_reuse = reuse;
    ifcfg_rddone = 1'($urandom); pat_done = 1'($urandom);
    drive_gbf(gmode);
    step();
    cyc = 0;
    while (m_phase != P_IDLE && cyc < 2000) begin
      rst = (rst_at >= 0 && m_phase == P_CMP && m_k == rst_at);
      start = ($urandom % 8 == 0);
      cfg_reuse = 1'($urandom);
      if (m_phase == P_CFG) begin
        ifcfg_rddone = ($urandom % 3 == 0);
        cfg_num_layer = LW'(l); cfg_num_frm = FW'(f); cfg_num_pat = PW'(p);
      end else begin
        ifcfg_rddone = 1'($urandom);
        cfg_num_layer = LW'($urandom); cfg_num_frm = FW'($urandom); cfg_num_pat = PW'($urandom);
      end
      drive_gbf(gmode);
      pat_done = (m_phase == P_CMP) ? (pd_all || 1'($urandom)) : 1'($urandom);
      step();
      cyc++;
    end
    chk("run_budget", 32'(cyc < 2000), 32'd1);
    rst = 1'b0; start = 1'b0; pat_done = 1'b0; ifcfg_rddone = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      pat_done = 1'($urandom);
      ifcfg_rddone = 1'($urandom);
      gbf_val = NG'($urandom);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle_steps(3);

    // Minimal run: single patch, banks already valid.
    run(1'b0, 0, 0, 0, 2, 1'b1, -1);
    chk("min_rst_frm",  32'(obs_rf), 32'd0);
    chk("min_net_done", 32'(obs_nd), 32'd1);
    chk("min_rst_lay",  32'(obs_rl), 32'd1);

    // Full nest with back-to-back pat_done: 2 layers x 3 frames x 4 patches.
    run(1'b0, 1, 2, 3, 2, 1'b1, -1);
    chk("nest_rst_frm",  32'(obs_rf), 32'd4);
    chk("nest_rst_lay",  32'(obs_rl), 32'd2);
    chk("nest_top_sta",  32'(obs_ts), 32'd2);
    chk("nest_net_done", 32'(obs_nd), 32'd1);

    // Partial bank valid held on every wait.
    run(1'b0, 0, 1, 1, 1, 1'b0, -1);
    chk("part_top_sta", 32'(obs_ts), 32'd1);

    // Reuse of the stored config skips CFG entirely.
    run(1'b1, 5, 5, 5, 0, 1'b0, -1);
    chk("reuse_cfg_req", 32'(obs_cfg), 32'd0);

    // After a reset the reuse request must fetch config again.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(1'b1, 0, 0, 2, 0, 1'b0, -1);
    chk("reuse_after_rst", 32'(obs_cfg > 0), 32'd1);

    // Reset at patch 5 of layer 1 (16 patches per layer), then stray pat_done.
    run(1'b0, 2, 1, 7, 0, 1'b0, 21);
    idle_steps(8);

    // Randomized runs.
    for (int i = 0; i < 8; i++) begin
      run(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), -1);
      idle_steps(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
